tmac_tx_sched: RTL



---
 rtl/tmac_tx_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tmac_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tmac_tx_sched                                                |
// | Description : Three-channel TMAC transmit scheduler. Arbitrates the        |
// |               per-channel frame-ready flags, times each frame from its     |
// |               latched length, enforces the inter-packet gap and pulses a   |
// |               per-channel acknowledge on completion or discard.            |
// | Options     : TMAC_SCHED_STRICT_PRI_EN - fixed priority ch0 > ch1 > ch2    |
// |               (undefined: round robin starting at rr_ptr)                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tmac_tx_sched #(
  parameter int LEN_W  = 10,
  parameter int CH_NUM = 3
) (
  input  logic              clk125m,
  input  logic              rst,
  input  logic [CH_NUM-1:0] pkt_com,
  input  logic [CH_NUM-1:0] rdi_en,
  input  logic [LEN_W-1:0]  tpkt_length0,
  input  logic [LEN_W-1:0]  tpkt_length1,
  input  logic [LEN_W-1:0]  tpkt_length2,
  input  logic [3:0]        ipg_th,
  output logic [CH_NUM-1:0] grant,
  output logic              tx_en,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [LEN_W-1:0]  tx_cnt,
  output logic [CH_NUM-1:0] pkt_ack,
  output logic              busy
);

  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_SEND    = 2'd1;
  localparam logic [1:0]       S_IPG     = 2'd2;
  localparam logic [LEN_W-1:0] c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CH_NUM-1:0] c_CH_ONE = {{(CH_NUM-1){1'b0}}, 1'b1};

  logic [1:0]        r_state, w_state_nxt;
  logic [1:0]        r_win;
  logic [LEN_W-1:0]  r_len_q;
  logic [3:0]        r_ipg_cnt;
  logic [CH_NUM-1:0] r_grant, r_pkt_ack;
  logic              r_tx_en, r_tx_sop, r_tx_eop, r_busy;
  logic [LEN_W-1:0]  r_tx_cnt;

  logic [CH_NUM-1:0] w_elig;
  logic              w_found;
  logic [1:0]        w_win;
  logic [LEN_W-1:0]  w_len_sel;
  logic [3:0]        w_ipg_g;
  logic              w_grant_now;
  logic [1:0]        w_win_nxt;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [CH_NUM-1:0] w_grant_nxt, w_pkt_ack_nxt;
  logic              w_tx_en_nxt, w_tx_sop_nxt, w_tx_eop_nxt, w_busy_nxt;
  logic [LEN_W-1:0]  w_tx_cnt_nxt;

  assign w_elig      = pkt_com & rdi_en;
  assign w_found     = |w_elig;
  // An ipg_th of 0 still yields one gap cycle.
  assign w_ipg_g     = (ipg_th == 4'd0) ? 4'd1 : ipg_th;
  assign w_grant_now = (r_state == S_IDLE) && w_found;

`ifdef TMAC_SCHED_STRICT_PRI_EN
  // Fixed priority winner: lowest channel index wins.
  always_comb begin
    w_win = 2'd0;
    if (w_elig[0])      w_win = 2'd0;
    else if (w_elig[1]) w_win = 2'd1;
    else if (w_elig[2]) w_win = 2'd2;
  end
`else
  logic [1:0] r_rr_ptr;

  // Round-robin winner: search starts at rr_ptr and wraps 0->1->2->0.
  always_comb begin
    w_win = 2'd0;
    case (r_rr_ptr)
      2'd1: begin
        if (w_elig[1])      w_win = 2'd1;
        else if (w_elig[2]) w_win = 2'd2;
        else if (w_elig[0]) w_win = 2'd0;
      end
      2'd2: begin
        if (w_elig[2])      w_win = 2'd2;
        else if (w_elig[0]) w_win = 2'd0;
        else if (w_elig[1]) w_win = 2'd1;
      end
      default: begin
        if (w_elig[0])      w_win = 2'd0;
        else if (w_elig[1]) w_win = 2'd1;
        else if (w_elig[2]) w_win = 2'd2;
      end
    endcase
  end

  // Pointer moves past the winner on every grant or zero-length discard.
  always_ff @(posedge clk125m) begin
    if (rst)              r_rr_ptr <= 2'd0;
    else if (w_grant_now) r_rr_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
  end
`endif

  // Length of the candidate winner, sampled only at grant time.
  always_comb begin
    case (w_win)
      2'd1:    w_len_sel = tpkt_length1;
      2'd2:    w_len_sel = tpkt_length2;
      default: w_len_sel = tpkt_length0;
    endcase
  end

  // State register.
  always_ff @(posedge clk125m) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a zero-length frame skips SEND and goes straight to IPG.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = (w_len_sel == '0) ? S_IPG : S_SEND;
      S_SEND: if (r_tx_cnt == r_len_q - c_LEN_ONE) w_state_nxt = S_IPG;
      S_IPG:  if (r_ipg_cnt <= 4'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next output values, computed from the next state so every output is registered.
  always_comb begin
    w_win_nxt     = w_grant_now ? w_win : r_win;
    w_len_nxt     = w_grant_now ? w_len_sel : r_len_q;
    w_tx_en_nxt   = (w_state_nxt == S_SEND);
    w_tx_sop_nxt  = w_grant_now && (w_state_nxt == S_SEND);
    w_tx_cnt_nxt  = '0;
    if (r_state == S_SEND && w_state_nxt == S_SEND) w_tx_cnt_nxt = r_tx_cnt + c_LEN_ONE;
    w_tx_eop_nxt  = w_tx_en_nxt && (w_tx_cnt_nxt == w_len_nxt - c_LEN_ONE);
    w_grant_nxt   = w_tx_en_nxt ? (c_CH_ONE << w_win_nxt) : '0;
    w_pkt_ack_nxt = '0;
    if (r_state != S_IPG && w_state_nxt == S_IPG) w_pkt_ack_nxt = c_CH_ONE << w_win_nxt;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
  end

  // Frame context, gap counter and output registers.
  always_ff @(posedge clk125m) begin
    if (rst) begin
      r_win     <= 2'd0;
      r_len_q   <= '0;
      r_ipg_cnt <= 4'd0;
      r_grant   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_sop  <= 1'b0;
      r_tx_eop  <= 1'b0;
      r_tx_cnt  <= '0;
      r_pkt_ack <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_win   <= w_win_nxt;
      r_len_q <= w_len_nxt;
      if (r_state != S_IPG && w_state_nxt == S_IPG) r_ipg_cnt <= w_ipg_g;
      else if (r_state == S_IPG)                    r_ipg_cnt <= r_ipg_cnt - 4'd1;
      r_grant   <= w_grant_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_sop  <= w_tx_sop_nxt;
      r_tx_eop  <= w_tx_eop_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
      r_pkt_ack <= w_pkt_ack_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign grant   = r_grant;
  assign tx_en   = r_tx_en;
  assign tx_sop  = r_tx_sop;
  assign tx_eop  = r_tx_eop;
  assign tx_cnt  = r_tx_cnt;
  assign pkt_ack = r_pkt_ack;
  assign busy    = r_busy;

endmodule
`default_nettype wire
